// File: rtl/rd_delay_pipe.sv
// Destination-register delay pipeline with per-stage valid, stall, flush
// and combinational rs1/rs2 hazard match against every in-flight stage.
module rd_delay_pipe #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 3,
  parameter int ZERO_NULL = 1,
  localparam int IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic [DEPTH-1:0]       flush_mask,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [DEPTH*WIDTH-1:0] tap_data,
  output logic [DEPTH-1:0]       tap_valid,
  input  logic [WIDTH-1:0]       rs1,
  input  logic [WIDTH-1:0]       rs2,
  output logic [DEPTH-1:0]       hit1,
  output logic [DEPTH-1:0]       hit2,
  output logic                   hit1_any,
  output logic                   hit2_any,
  output logic [IDXW-1:0]        hit1_idx,
  output logic [IDXW-1:0]        hit2_idx
);

  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_valid;

  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;
  logic [IDXW-1:0]  w_idx1;
  logic [IDXW-1:0]  w_idx2;
  logic             w_q1_ok;
  logic             w_q2_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= '0;
    end else if (stall) begin
      r_valid <= r_valid & ~flush_mask;
    end else begin
      r_data[0]  <= in;
      r_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1] & ~flush_mask[i-1];
      end
    end
  end

  // x0 never hazards when ZERO_NULL is set
  assign w_q1_ok = !((ZERO_NULL != 0) && (rs1 == '0));
  assign w_q2_ok = !((ZERO_NULL != 0) && (rs2 == '0));

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = r_valid[i] && (r_data[i] == rs1) && w_q1_ok;
      w_hit2[i] = r_valid[i] && (r_data[i] == rs2) && w_q2_ok;
    end
  end

  always_comb begin
    w_idx1 = '0;
    w_idx2 = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_hit1[i]) w_idx1 = IDXW'(i);
      if (w_hit2[i]) w_idx2 = IDXW'(i);
    end
  end

  assign out       = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];
  assign tap_data  = r_data;
  assign tap_valid = r_valid;
  assign hit1      = w_hit1;
  assign hit2      = w_hit2;
  assign hit1_any  = |w_hit1;
  assign hit2_any  = |w_hit2;
  assign hit1_idx  = w_idx1;
  assign hit2_idx  = w_idx2;

endmodule

// File: tb/tb_rd_delay_pipe.sv
// Bench for rd_delay_pipe: directed scenarios plus a random stream
// compared every cycle against a behavioural model.
module tb_rd_delay_pipe;

  localparam int W = 5;
  localparam int D = 3;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_d;
  logic         in_valid;
  logic         stall;
  logic [D-1:0] flush_mask;
  logic [W-1:0] rs1, rs2;
  logic [W-1:0] out;
  logic         out_valid;
  logic [D*W-1:0] tap_data;
  logic [D-1:0] tap_valid;
  logic [D-1:0] hit1, hit2;
  logic         hit1_any, hit2_any;
  logic [1:0]   hit1_idx, hit2_idx;

  int n_checks = 0;
  int n_errs   = 0;

  int m_d[D];
  bit m_v[D];

  rd_delay_pipe #(.WIDTH(W), .DEPTH(D), .ZERO_NULL(1)) dut (
    .clk(clk), .reset(reset), .in(in_d), .in_valid(in_valid),
    .stall(stall), .flush_mask(flush_mask),
    .out(out), .out_valid(out_valid),
    .tap_data(tap_data), .tap_valid(tap_valid),
    .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2),
    .hit1_any(hit1_any), .hit2_any(hit2_any),
    .hit1_idx(hit1_idx), .hit2_idx(hit2_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_hits(input int rs, output int vec,
                                     output int idx);
    vec = 0;
    idx = -1;
    for (int i = 0; i < D; i++)
      if (m_v[i] && m_d[i] == rs && rs != 0) begin
        vec |= (1 << i);
        if (idx < 0) idx = i;
      end
    if (idx < 0) idx = 0;
  endfunction

  task automatic check_all();
    int tv, td, v1, i1, v2, i2;
    tv = 0;
    td = 0;
    for (int i = 0; i < D; i++) begin
      tv |= int'(m_v[i]) << i;
      td |= m_d[i] << (i * W);
    end
    model_hits(int'(rs1), v1, i1);
    model_hits(int'(rs2), v2, i2);
    check("out",       32'(out),       32'(m_d[D-1]));
    check("out_valid", 32'(out_valid), 32'(m_v[D-1]));
    check("tap_data",  32'(tap_data),  32'(td));
    check("tap_valid", 32'(tap_valid), 32'(tv));
    check("hit1",      32'(hit1),      32'(v1));
    check("hit2",      32'(hit2),      32'(v2));
    check("hit1_any",  32'(hit1_any),  32'(v1 != 0));
    check("hit2_any",  32'(hit2_any),  32'(v2 != 0));
    check("hit1_idx",  32'(hit1_idx),  32'(i1));
    check("hit2_idx",  32'(hit2_idx),  32'(i2));
  endtask

  // Advance one edge: model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        m_d[i] = 0;
        m_v[i] = 0;
      end
    end else if (stall) begin
      for (int i = 0; i < D; i++)
        if (flush_mask[i]) m_v[i] = 0;
    end else begin
      for (int i = D - 1; i >= 1; i--) begin
        m_d[i] = m_d[i-1];
        m_v[i] = m_v[i-1] && !flush_mask[i-1];
      end
      m_d[0] = int'(in_d);
      m_v[0] = in_valid;
    end
    #1;
    check_all();
  endtask

  task automatic push(input int v, input bit vld);
    in_d = W'(v);
    in_valid = vld;
    tick();
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      m_d[i] = 0;
      m_v[i] = 0;
    end
    reset = 1'b1; in_d = '0; in_valid = 1'b0; stall = 1'b0;
    flush_mask = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    check("rst_out", 32'(out), 0);
    check("rst_tapv", 32'(tap_valid), 0);
    reset = 1'b0;

    // stream 1..4: first output on third edge
    for (int k = 1; k <= 6; k++) begin
      push(k, k <= 4);
      if (k >= 3) begin
        check("stream_out", 32'(out), 32'(k - 2));
        check("stream_ov", 32'(out_valid), 1);
      end else begin
        check("stream_ov0", 32'(out_valid), 0);
      end
    end

    // stall holds contents and drops input
    push(7, 1); push(5, 1); push(9, 1);
    stall = 1'b1;
    push(12, 1);
    push(12, 1);
    check("stall_tap", 32'(tap_data), 32'({5'd7, 5'd5, 5'd9}));
    stall = 1'b0;
    push(12, 1);
    check("unstall_tap", 32'(tap_data), 32'({5'd5, 5'd9, 5'd12}));

    // flush on shift
    push(7, 1); push(5, 1); push(9, 1);
    flush_mask = 3'b010;
    push(1, 1);
    flush_mask = '0;
    check("flush_tapv", 32'(tap_valid), 32'(3'b011));
    check("flush_out", 32'(out), 5);
    check("flush_ov", 32'(out_valid), 0);

    // flush while stalled
    push(7, 1); push(5, 1); push(9, 1);
    stall = 1'b1;
    flush_mask = 3'b010;
    push(1, 1);
    stall = 1'b0;
    flush_mask = '0;
    check("sflush_tapv", 32'(tap_valid), 32'(3'b101));
    check("sflush_tap", 32'(tap_data), 32'({5'd7, 5'd5, 5'd9}));

    // hazard compare
    push(6, 1); push(4, 1); push(4, 1);
    rs1 = 5'd4; rs2 = 5'd6;
    #1;
    check("haz_hit1", 32'(hit1), 32'(3'b011));
    check("haz_idx1", 32'(hit1_idx), 0);
    check("haz_hit2", 32'(hit2), 32'(3'b100));
    check("haz_idx2", 32'(hit2_idx), 2);
    check("haz_any", 32'({hit1_any, hit2_any}), 3);
    push(0, 1);
    rs1 = 5'd0;
    #1;
    check("zero_hit1", 32'(hit1), 0);
    check("zero_any1", 32'(hit1_any), 0);

    // reset mid-stream
    push(3, 1); push(8, 1); push(11, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_tapv", 32'(tap_valid), 0);
    check("mrst_tap", 32'(tap_data), 0);
    push(17, 1);
    push(0, 0);
    check("mrst_ov_early", 32'(out_valid), 0);
    push(0, 0);
    check("mrst_out", 32'({out_valid, out}), 32'({1'b1, 5'd17}));

    // random stream against the model
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(99) == 0);
      stall      = ($urandom_range(3) == 0);
      flush_mask = ($urandom_range(4) == 0) ? D'($urandom) : '0;
      rs1        = W'($urandom_range(7));
      rs2        = W'($urandom_range(7));
      push(($urandom_range(3) == 0) ? int'($urandom_range(31))
                                    : int'($urandom_range(7)),
           $urandom_range(4) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
